pulse_param_loader: RTL and testbench



---
 rtl/pulse_param_loader_if.sv | 28 ++
 rtl/pulse_param_loader.sv | 206 ++++++++++++++++++++
 tb/tb_pulse_param_loader.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_param_loader_if.sv
// ============================================================================
//  Module      : pulse_param_loader_if
//  Description : Byte stream from the UART receiver and acknowledge return path
//                toward the UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface pulse_param_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid
  );
endinterface

`default_nettype wire

// File: rtl/pulse_param_loader.sv
// ============================================================================
//  Module      : pulse_param_loader
//  Description : Parses address/payload byte frames into the pulse parameter
//                registers, commits atomically and returns a one-byte ack.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module pulse_param_loader #(
  parameter int unsigned  TIMEOUT_CYC = 1200000,
  parameter logic [7:0]   ST_PERIOD   = 8'd1,
  parameter logic [15:0]  ST_P1WIDTH  = 16'd30,
  parameter logic [15:0]  ST_DELAY    = 16'd200,
  parameter logic [15:0]  ST_P2WIDTH  = 16'd60,
  parameter logic [31:0]  ST_NUTDEL   = 32'd300,
  parameter logic [31:0]  ST_NUTWID   = 32'd300,
  parameter logic [2:0]   ST_FLAGS    = 3'b111,
  parameter logic [7:0]   ST_BLOCK    = 8'd50,
  parameter logic [15:0]  ST_BLOCKOFF = 16'd100,
  parameter logic [7:0]   ST_CPMG     = 8'd1
) (
  input  logic                  clk,
  input  logic                  resetn,
  pulse_param_loader_if.slave   bus,
  output logic [7:0]            period,
  output logic [15:0]           p1width,
  output logic [15:0]           delay,
  output logic [15:0]           p2width,
  output logic [31:0]           nut_del,
  output logic [31:0]           nut_wid,
  output logic                  pump,
  output logic                  block,
  output logic                  nutation,
  output logic [7:0]            pulse_block,
  output logic [15:0]           pulse_block_off,
  output logic [7:0]            cpmg,
  output logic                  rx_done,
  output logic                  frame_err
);

  localparam logic [23:0] c_tmo_last = 24'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  c_addr_dflt = 8'hFF;
  localparam logic [7:0]  c_ack_err   = 8'hEE;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_addr;
  logic [1:0]  r_last;
  logic [1:0]  r_cnt;
  logic [31:0] r_shadow;
  logic [23:0] r_tmo;
  logic        r_rx_done, r_frame_err;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;

  logic [7:0]  r_period, r_pulse_block, r_cpmg;
  logic [15:0] r_p1width, r_delay, r_p2width, r_pulse_block_off;
  logic [31:0] r_nut_del, r_nut_wid;
  logic [2:0]  r_flags;

  logic w_latch_addr, w_take_byte, w_err, w_commit;

  // Payload length minus one, so the last byte is recognised by a 2-bit counter
  function automatic logic [1:0] f_last(input logic [7:0] a);
    case (a)
      8'd1, 8'd2, 8'd3, 8'd8: f_last = 2'd1;
      8'd4, 8'd5:             f_last = 2'd3;
      default:                f_last = 2'd0;
    endcase
  endfunction

  assign w_commit = (r_state == S_COMMIT);

  always_ff @(posedge clk) begin
    if (resetn) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_latch_addr = 1'b0;
    w_take_byte  = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      S_IDLE, S_COMMIT: begin
        w_state_nxt = S_IDLE;
        if (bus.rx_valid) begin
          if (bus.rx_data <= 8'd9) begin
            w_latch_addr = 1'b1;
            w_state_nxt  = S_PAYLOAD;
          end else if (bus.rx_data == c_addr_dflt) begin
            w_latch_addr = 1'b1;
            w_state_nxt  = S_COMMIT;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (bus.rx_valid) begin
          w_take_byte = 1'b1;
          if (r_cnt == r_last) w_state_nxt = S_COMMIT;
        end else if (r_tmo == c_tmo_last) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      r_addr      <= 8'd0;
      r_last      <= 2'd0;
      r_cnt       <= 2'd0;
      r_shadow    <= 32'd0;
      r_tmo       <= 24'd0;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
      r_tx_data   <= 8'd0;
      r_tx_valid  <= 1'b0;
    end else begin
      r_rx_done   <= w_commit;
      r_frame_err <= w_err;
      if (r_state == S_PAYLOAD) r_tmo <= r_tmo + 24'd1;
      if (w_latch_addr) begin
        r_addr   <= bus.rx_data;
        r_last   <= f_last(bus.rx_data);
        r_cnt    <= 2'd0;
        r_shadow <= 32'd0;
        r_tmo    <= 24'd0;
      end
      if (w_take_byte) begin
        r_shadow[{r_cnt, 3'b000} +: 8] <= bus.rx_data;
        r_cnt <= r_cnt + 2'd1;
        r_tmo <= 24'd0;
      end
      // A newly queued ack always replaces a pending one, even on tx_ready
      if (w_err) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= c_ack_err;
      end else if (w_commit) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= r_addr;
      end else if (bus.tx_ready) begin
        r_tx_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn || (w_commit && r_addr == c_addr_dflt)) begin
      r_period          <= ST_PERIOD;
      r_p1width         <= ST_P1WIDTH;
      r_delay           <= ST_DELAY;
      r_p2width         <= ST_P2WIDTH;
      r_nut_del         <= ST_NUTDEL;
      r_nut_wid         <= ST_NUTWID;
      r_flags           <= ST_FLAGS;
      r_pulse_block     <= ST_BLOCK;
      r_pulse_block_off <= ST_BLOCKOFF;
      r_cpmg            <= ST_CPMG;
    end else if (w_commit) begin
      case (r_addr)
        8'd0: r_period          <= r_shadow[7:0];
        8'd1: r_p1width         <= r_shadow[15:0];
        8'd2: r_delay           <= r_shadow[15:0];
        8'd3: r_p2width         <= r_shadow[15:0];
        8'd4: r_nut_del         <= r_shadow;
        8'd5: r_nut_wid         <= r_shadow;
        8'd6: r_flags           <= r_shadow[2:0];
        8'd7: r_pulse_block     <= r_shadow[7:0];
        8'd8: r_pulse_block_off <= r_shadow[15:0];
        8'd9: r_cpmg            <= r_shadow[7:0];
        default: ;
      endcase
    end
  end

  assign period          = r_period;
  assign p1width         = r_p1width;
  assign delay           = r_delay;
  assign p2width         = r_p2width;
  assign nut_del         = r_nut_del;
  assign nut_wid         = r_nut_wid;
  assign nutation        = r_flags[2];
  assign block           = r_flags[1];
  assign pump            = r_flags[0];
  assign pulse_block     = r_pulse_block;
  assign pulse_block_off = r_pulse_block_off;
  assign cpmg            = r_cpmg;
  assign rx_done         = r_rx_done;
  assign frame_err       = r_frame_err;
  assign bus.tx_data     = r_tx_data;
  assign bus.tx_valid    = r_tx_valid;

endmodule

`default_nettype wire

// File: tb/tb_pulse_param_loader.sv
// ============================================================================
//  Module      : tb_pulse_param_loader
//  Description : Self-checking bench for pulse_param_loader (frame table,
//                commit scoreboard and hand-written corner sequences).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pulse_param_loader;

  localparam int unsigned c_tmo = 16;
  localparam int          c_nvec = 13;

  typedef struct packed {
    logic [7:0]  period;
    logic [15:0] p1width;
    logic [15:0] delay;
    logic [15:0] p2width;
    logic [31:0] nut_del;
    logic [31:0] nut_wid;
    logic        nutation;
    logic        block;
    logic        pump;
    logic [7:0]  pulse_block;
    logic [15:0] pulse_block_off;
    logic [7:0]  cpmg;
  } params_t;

  typedef struct packed {
    params_t    p;
    logic [7:0] ack;
  } exp_t;

  typedef struct {
    logic [7:0]  addr;
    int          n;
    logic [31:0] pay;
    logic [31:0] exp_val;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  pulse_param_loader_if bus ();

  logic [7:0]  w_period, w_pulse_block, w_cpmg;
  logic [15:0] w_p1width, w_delay, w_p2width, w_pulse_block_off;
  logic [31:0] w_nut_del, w_nut_wid;
  logic        w_pump, w_block, w_nutation, w_rx_done, w_frame_err;

  pulse_param_loader #(.TIMEOUT_CYC(c_tmo)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .bus             (bus),
    .period          (w_period),
    .p1width         (w_p1width),
    .delay           (w_delay),
    .p2width         (w_p2width),
    .nut_del         (w_nut_del),
    .nut_wid         (w_nut_wid),
    .pump            (w_pump),
    .block           (w_block),
    .nutation        (w_nutation),
    .pulse_block     (w_pulse_block),
    .pulse_block_off (w_pulse_block_off),
    .cpmg            (w_cpmg),
    .rx_done         (w_rx_done),
    .frame_err       (w_frame_err)
  );

  int      n_cmp = 0;
  int      n_err = 0;
  exp_t    q[$];
  params_t model;
  vec_t    vecs[c_nvec];

  function automatic params_t defaults();
    params_t p;
    p.period = 8'd1;          p.p1width = 16'd30;   p.delay = 16'd200;
    p.p2width = 16'd60;       p.nut_del = 32'd300;  p.nut_wid = 32'd300;
    p.nutation = 1'b1;        p.block = 1'b1;       p.pump = 1'b1;
    p.pulse_block = 8'd50;    p.pulse_block_off = 16'd100;  p.cpmg = 8'd1;
    return p;
  endfunction

  function automatic params_t apply(input params_t m, input logic [7:0] a, input logic [31:0] pay);
    params_t p = m;
    case (a)
      8'd0: p.period = pay[7:0];
      8'd1: p.p1width = pay[15:0];
      8'd2: p.delay = pay[15:0];
      8'd3: p.p2width = pay[15:0];
      8'd4: p.nut_del = pay;
      8'd5: p.nut_wid = pay;
      8'd6: {p.nutation, p.block, p.pump} = pay[2:0];
      8'd7: p.pulse_block = pay[7:0];
      8'd8: p.pulse_block_off = pay[15:0];
      8'd9: p.cpmg = pay[7:0];
      8'hFF: p = defaults();
      default: ;
    endcase
    return p;
  endfunction

  function automatic params_t snap();
    params_t p;
    p.period = w_period;           p.p1width = w_p1width;   p.delay = w_delay;
    p.p2width = w_p2width;         p.nut_del = w_nut_del;   p.nut_wid = w_nut_wid;
    p.nutation = w_nutation;       p.block = w_block;       p.pump = w_pump;
    p.pulse_block = w_pulse_block; p.pulse_block_off = w_pulse_block_off;
    p.cpmg = w_cpmg;
    return p;
  endfunction

  function automatic logic [31:0] field(input logic [7:0] a);
    case (a)
      8'd0: return {24'd0, w_period};
      8'd1: return {16'd0, w_p1width};
      8'd2: return {16'd0, w_delay};
      8'd3: return {16'd0, w_p2width};
      8'd4: return w_nut_del;
      8'd5: return w_nut_wid;
      8'd6: return {29'd0, w_nutation, w_block, w_pump};
      8'd7: return {24'd0, w_pulse_block};
      8'd8: return {16'd0, w_pulse_block_off};
      8'd9: return {24'd0, w_cpmg};
      default: return {24'd0, w_period};
    endcase
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after posedge; each call leaves rx_valid low so calls chain back-to-back
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input int n, input logic [31:0] pay, input bit push);
    logic [31:0] w;
    if (push) begin
      model = apply(model, a, pay);
      q.push_back({model, a});
    end
    w = pay;
    send_byte(a);
    for (int i = 0; i < n; i++) send_byte(w[8*i +: 8]);
  endtask

  // Scoreboard: every rx_done must match the oldest queued commit
  always @(negedge clk) begin
    exp_t e;
    if (!resetn && w_rx_done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rx_done: got rx_done=1 with ack %0h, expected no commit", bus.tx_data);
      end else begin
        e = q.pop_front();
        chk("commit_params", snap(), e.p);
        chk("commit_ack", {bus.tx_valid, bus.tx_data}, {1'b1, e.ack});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    vecs[0]  = '{8'h06, 1, 32'h0000_0002, 32'h0000_0002};
    vecs[1]  = '{8'hFF, 0, 32'h0,         32'h0000_0001};
    vecs[2]  = '{8'h00, 1, 32'h0000_00A5, 32'h0000_00A5};
    vecs[3]  = '{8'h01, 2, 32'h0000_1234, 32'h0000_1234};
    vecs[4]  = '{8'h02, 2, 32'h0000_FFFF, 32'h0000_FFFF};
    vecs[5]  = '{8'h03, 2, 32'h0000_BEEF, 32'h0000_BEEF};
    vecs[6]  = '{8'h04, 4, 32'h8000_0001, 32'h8000_0001};
    vecs[7]  = '{8'h05, 4, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[8]  = '{8'h06, 1, 32'h0000_00FD, 32'h0000_0005};
    vecs[9]  = '{8'h07, 1, 32'h0000_007E, 32'h0000_007E};
    vecs[10] = '{8'h08, 2, 32'h0000_CAFE, 32'h0000_CAFE};
    vecs[11] = '{8'h09, 1, 32'h0000_0003, 32'h0000_0003};
    vecs[12] = '{8'hFF, 0, 32'h0,         32'h0000_0001};

    bus.rx_data  = 8'd0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    model = defaults();
    idle(3);
    resetn = 1'b0;
    idle(2);

    // Reset state
    chk("reset_params", snap(), defaults());
    chk("reset_tx", {bus.tx_valid, bus.tx_data}, 9'd0);
    chk("reset_strobes", {w_rx_done, w_frame_err}, 2'b00);

    // 4-byte write: latency, single-cycle rx_done, held ack
    send_frame(8'h04, 4, 32'h1234_5678, 1'b1);
    chk("lat_before", {w_rx_done, w_nut_del}, {1'b0, 32'd300});
    idle(1);
    chk("lat_after", {w_rx_done, w_nut_del}, {1'b1, 32'h1234_5678});
    idle(1);
    chk("rx_done_one_cycle", w_rx_done, 1'b0);
    chk("others_unchanged", snap(), model);
    idle(3);
    chk("ack_held", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h04});
    bus.tx_ready = 1'b1;
    idle(1);
    chk("ack_released", bus.tx_valid, 1'b0);

    // Table-driven frames over every address and load-defaults
    for (int i = 0; i < c_nvec; i++) begin
      send_frame(vecs[i].addr, vecs[i].n, vecs[i].pay, 1'b1);
      idle(2);
      chk($sformatf("vec%0d_field", i), field(vecs[i].addr), vecs[i].exp_val);
    end

    // Invalid address
    bus.tx_ready = 1'b0;
    send_byte(8'h0C);
    chk("bad_addr_err", {w_frame_err, bus.tx_valid, bus.tx_data}, {1'b1, 1'b1, 8'hEE});
    idle(1);
    chk("bad_addr_err_one_cycle", w_frame_err, 1'b0);

    // Inter-byte timeout after an address with no payload
    send_byte(8'h01);
    lat = 0;
    for (int i = 1; i <= int'(c_tmo) + 10; i++) begin
      idle(1);
      if (w_frame_err) begin
        lat = i;
        break;
      end
    end
    chk("timeout_cycles", lat, c_tmo);
    chk("timeout_ack", {bus.tx_valid, bus.tx_data}, {1'b1, 8'hEE});
    chk("timeout_p1width", w_p1width, 16'd30);

    // Back-to-back frames, ack never drained
    send_frame(8'h02, 2, 32'h0000_03E8, 1'b1);
    send_frame(8'h00, 1, 32'h0000_0005, 1'b1);
    idle(2);
    chk("b2b_delay", w_delay, 16'd1000);
    chk("b2b_period", w_period, 8'd5);
    chk("b2b_latest_ack", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h00});

    // Reset in the middle of a frame discards it
    bus.tx_ready = 1'b1;
    send_byte(8'h05);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    resetn = 1'b1;
    idle(1);
    resetn = 1'b0;
    model = defaults();
    idle(1);
    chk("midreset_params", snap(), defaults());
    chk("midreset_tx_valid", bus.tx_valid, 1'b0);
    send_frame(8'h05, 4, 32'h0000_0010, 1'b1);
    idle(2);
    chk("after_reset_nut_wid", w_nut_wid, 32'd16);

    idle(2);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
